// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, register-address/word types
// and the hardwired zero-register index.
package pipe_pkg;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when the address names the hardwired zero register.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: MEM/WB inputs, decode read ports and
// debug outputs. The master side is the pipeline, the slave side is wb_regfile.
interface wb_regfile_if #(
    parameter int CW = 32
);
    import pipe_pkg::*;

    logic             write_MW;
    logic             MemtoReg_MW;
    reg_addr_t        Rd_addr;
    word_t            Mrdata_MW;
    word_t            ALUResult_MW;
    reg_addr_t        rs_addr;
    reg_addr_t        rt_addr;
    word_t            rs_data;
    word_t            rt_data;
    word_t            wb_data;
    logic             wb_valid;
    logic [CW-1:0]    retire_count;

    modport master (
        output write_MW, MemtoReg_MW, Rd_addr, Mrdata_MW, ALUResult_MW,
               rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_valid, retire_count
    );

    modport slave (
        input  write_MW, MemtoReg_MW, Rd_addr, Mrdata_MW, ALUResult_MW,
               rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_valid, retire_count
    );

endinterface

// File: rtl/wb_regfile_regfile_core.sv
// Architectural register storage: one synchronous write port, two
// asynchronous read ports, register 0 reads as zero, synchronous clear.
module regfile_core
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  word_t     wdata_i,
    input  reg_addr_t raddr_a_i,
    input  reg_addr_t raddr_b_i,
    output word_t     rdata_a_o,
    output word_t     rdata_b_o
);

    word_t regs_q [NREG];

    // Storage update: clear everything on reset, otherwise commit one write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
        end else if (we_i && !is_zero_reg(waddr_i)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous reads with register 0 forced to zero.
    always_comb begin
        rdata_a_o = {DW{1'b0}};
        rdata_b_o = {DW{1'b0}};
        if (!is_zero_reg(raddr_a_i)) begin
            rdata_a_o = regs_q[raddr_a_i];
        end else begin
            rdata_a_o = {DW{1'b0}};
        end
        if (!is_zero_reg(raddr_b_i)) begin
            rdata_b_o = regs_q[raddr_b_i];
        end else begin
            rdata_b_o = {DW{1'b0}};
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus register file: selects load data or ALU result,
// commits it, serves two decode read ports and counts retired writes.
// Optional macro WB_BYPASS_EN: read ports return the value being written
// back in the same cycle (write-through) instead of the stored value.
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);

    word_t         wb_data_s;
    logic          commit_s;
    word_t         core_a_s;
    word_t         core_b_s;
    logic          wb_valid_q, wb_valid_d;
    logic [CW-1:0] retire_q, retire_d;

    // Write-back mux and commit gate; reset always wins over a write.
    always_comb begin
        wb_data_s = bus.MemtoReg_MW ? bus.Mrdata_MW : bus.ALUResult_MW;
        commit_s  = bus.write_MW && !is_zero_reg(bus.Rd_addr) && !rst;
    end

    regfile_core u_core (
        .clk       (clk),
        .rst       (rst),
        .we_i      (commit_s),
        .waddr_i   (bus.Rd_addr),
        .wdata_i   (wb_data_s),
        .raddr_a_i (bus.rs_addr),
        .raddr_b_i (bus.rt_addr),
        .rdata_a_o (core_a_s),
        .rdata_b_o (core_b_s)
    );

    // Read-port selection; the core already zeroes register 0 reads.
    always_comb begin
        bus.rs_data = core_a_s;
        bus.rt_data = core_b_s;
`ifdef WB_BYPASS_EN
        if (commit_s && (bus.rs_addr == bus.Rd_addr)) begin
            bus.rs_data = wb_data_s;
        end else begin
            bus.rs_data = core_a_s;
        end
        if (commit_s && (bus.rt_addr == bus.Rd_addr)) begin
            bus.rt_data = wb_data_s;
        end else begin
            bus.rt_data = core_b_s;
        end
`endif
        bus.wb_data = wb_data_s;
    end

    // Next-state for the commit flag and the wrapping retire counter.
    always_comb begin
        wb_valid_d = 1'b0;
        retire_d   = retire_q;
        if (rst) begin
            wb_valid_d = 1'b0;
            retire_d   = {CW{1'b0}};
        end else if (commit_s) begin
            wb_valid_d = 1'b1;
            retire_d   = retire_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wb_valid_d = 1'b0;
            retire_d   = retire_q;
        end
    end

    // Debug/performance state registers.
    always_ff @(posedge clk) begin
        wb_valid_q <= wb_valid_d;
        retire_q   <= retire_d;
    end

    assign bus.wb_valid     = wb_valid_q;
    assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile (built with a 4-bit retire counter so
// wrap-around is reachable). Follows WB_BYPASS_EN when it is defined.
module tb_wb_regfile;

    localparam int CW = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference state: plain architectural view of the block.
    logic [31:0] model_regs [32];
    int          model_cnt;
    bit          model_valid;

    wb_regfile_if #(.CW(CW)) bus ();

    wb_regfile #(.CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input int addr, input bit commit,
                                             input int rd, input logic [31:0] wbd);
        if (addr == 0) return 32'd0;
        if (BYPASS && commit && addr == rd) return wbd;
        return model_regs[addr];
    endfunction

    // One pipeline cycle: drive, check combinational/registered outputs
    // mid-cycle, take the clock edge, then advance the reference model.
    task automatic cycle(input bit do_rst, input bit we, input bit m2r, input int rd,
                         input logic [31:0] mr, input logic [31:0] alu,
                         input int rs, input int rt);
        logic [31:0] wbd;
        bit          commit;
        rst              = do_rst;
        bus.write_MW     = we;
        bus.MemtoReg_MW  = m2r;
        bus.Rd_addr      = rd[4:0];
        bus.Mrdata_MW    = mr;
        bus.ALUResult_MW = alu;
        bus.rs_addr      = rs[4:0];
        bus.rt_addr      = rt[4:0];
        wbd    = m2r ? mr : alu;
        commit = we && (rd != 0) && !do_rst;
        #4;
        check_eq("wb_data", bus.wb_data, wbd);
        check_eq("rs_data", bus.rs_data, exp_read(rs, commit, rd, wbd));
        check_eq("rt_data", bus.rt_data, exp_read(rt, commit, rd, wbd));
        check_eq("wb_valid", {31'd0, bus.wb_valid}, {31'd0, model_valid});
        check_eq("retire_count", {28'd0, bus.retire_count}, model_cnt);
        @(posedge clk);
        if (do_rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
            model_cnt   = 0;
            model_valid = 1'b0;
        end else begin
            if (commit) begin
                model_regs[rd] = wbd;
                model_cnt      = (model_cnt + 1) % 16;
            end
            model_valid = commit;
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_cnt   = 0;
        model_valid = 1'b0;

        // Initial reset (DUT state is unknown before it, so no checks yet).
        rst = 1'b1;
        bus.write_MW = 1'b0; bus.MemtoReg_MW = 1'b0; bus.Rd_addr = 5'd0;
        bus.Mrdata_MW = 32'd0; bus.ALUResult_MW = 32'd0;
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Preload registers, then reset and sweep all addresses.
        for (int i = 1; i < 32; i++) cycle(0, 1, 0, i, 32'd0, 32'hA000_0000 + i, i, 32 - i);
        cycle(1, 0, 0, 0, 32'd0, 32'd0, 1, 2);
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 32'd0, 32'd0, i, (i + 7) % 32);
        check_eq("reset_cnt", {28'd0, bus.retire_count}, 32'd0);

        // Mux and commit, directed.
        cycle(0, 1, 1, 5, 32'hDEADBEEF, 32'h1234, 0, 0);
        cycle(0, 0, 0, 0, 32'd0, 32'd0, 5, 5);
        check_eq("load_path", bus.rs_data, 32'hDEADBEEF);
        cycle(0, 1, 0, 5, 32'hDEADBEEF, 32'h1234, 0, 0);
        cycle(0, 0, 0, 0, 32'd0, 32'd0, 5, 5);
        check_eq("alu_path", bus.rs_data, 32'h0000_1234);
        check_eq("cnt_two", {28'd0, bus.retire_count}, 32'd2);

        // Register zero write is dropped.
        cycle(0, 1, 0, 0, 32'd0, 32'hFFFFFFFF, 0, 0);
        check_eq("r0_valid", {31'd0, bus.wb_valid}, 32'd0);
        check_eq("r0_cnt", {28'd0, bus.retire_count}, 32'd2);
        check_eq("r0_read", bus.rs_data, 32'd0);

        // Same-cycle hazard on register 7.
        cycle(0, 1, 0, 7, 32'd0, 32'h11, 0, 0);
        cycle(0, 1, 0, 7, 32'd0, 32'h22, 7, 7);
        cycle(0, 0, 0, 0, 32'd0, 32'd0, 7, 7);
        check_eq("hazard_next", bus.rt_data, 32'h22);

        // Reset during a write: reset wins.
        cycle(1, 1, 0, 3, 32'd0, 32'h55, 0, 0);
        cycle(0, 0, 0, 0, 32'd0, 32'd0, 3, 3);
        check_eq("rst_mid_write", bus.rs_data, 32'd0);
        check_eq("rst_mid_cnt", {28'd0, bus.retire_count}, 32'd0);

        // Counter wrap: 17 commits on a 4-bit counter leaves 1.
        for (int i = 0; i < 17; i++) cycle(0, 1, 0, 10, 32'd0, i, 0, 0);
        check_eq("cnt_wrap", {28'd0, bus.retire_count}, 32'd1);

        // write_MW = 0 leaves register 9 untouched, wb_data still muxes.
        cycle(0, 1, 0, 9, 32'd0, 32'h99, 0, 0);
        cycle(0, 0, 1, 9, 32'hCAFE0000, 32'h77, 9, 9);
        cycle(0, 0, 0, 9, 32'hCAFE0000, 32'h77, 9, 9);
        check_eq("no_write_r9", bus.rs_data, 32'h99);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            int rd;
            int rs;
            int rt;
            rd = $urandom_range(0, 31);
            rs = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, 31);
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom_range(0, 31);
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  $urandom_range(0, 1), rd, $urandom, $urandom, rs, rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
